tlb_miss_sched: RTL and testbench

- Schedules the shared TLB miss handler between two requesters: instruction TLB (I) and data TLB (D).
- Accepts one miss at a time, waits a fixed walk latency, then forms physical address = vaddr + os_offset.
- Broadcasts the fill on one shared refill bus tagged with the destination TLB.
- Sits between the ITLB/DTLB miss outputs and their refill ports; serializes misses so only one translation is in flight.

---
 rtl/tlb_miss_sched.sv | 190 +++++++++++++++++++
 tb/tb_tlb_miss_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_miss_sched.sv
// -----------------------------------------------------------------------------
// tlb_miss_sched
//
// Serialises TLB misses from the instruction TLB (I) and the data TLB (D) onto
// one shared miss handler. One miss is accepted at a time. The handler walks
// for WALK_LAT cycles, then forms paddr = vaddr + os_offset (mod 2^ADDR_W).
// The result is broadcast on a single refill bus tagged with the destination.
//
// Build option:
//   TLB_MISS_SCHED_RR_EN  defined   -> round-robin arbitration on ties
//                         undefined -> fixed priority, D wins over I
//
// Parameters:
//   ADDR_W    address width (virtual and physical)
//   WALK_LAT  cycles spent walking per miss, 1..255
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   i_req / i_vaddr        ITLB miss (level, held until i_ack) and its address
//   i_ack                  one-cycle pulse, I miss accepted
//   d_req / d_vaddr        DTLB miss (level, held until d_ack) and its address
//   d_ack                  one-cycle pulse, D miss accepted
//   os_offset              translation offset, sampled on the WALK->FILL edge
//   fill_valid             one-cycle pulse, refill bus carries a result
//   fill_dest              refill target: 0 = ITLB, 1 = DTLB
//   fill_vaddr/fill_paddr  refilled virtual / translated physical address
//   busy                   high whenever the scheduler is not IDLE
// -----------------------------------------------------------------------------
module tlb_miss_sched #(
    parameter int ADDR_W   = 32,
    parameter int WALK_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_vaddr,
    output logic              i_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_vaddr,
    output logic              d_ack,
    input  logic [ADDR_W-1:0] os_offset,
    output logic              fill_valid,
    output logic              fill_dest,
    output logic [ADDR_W-1:0] fill_vaddr,
    output logic [ADDR_W-1:0] fill_paddr,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        FILL = 2'd2
    } state_t;

    // The counter counts down to zero, so a load of WALK_LAT-1 yields exactly
    // WALK_LAT cycles in WALK.
    localparam logic [7:0] CNT_LOAD = 8'(WALK_LAT - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   lat_vaddr_q, lat_vaddr_d;
    logic                lat_dest_q, lat_dest_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                fill_valid_q, fill_valid_d;
    logic                fill_dest_q, fill_dest_d;
    logic [ADDR_W-1:0]   fill_vaddr_q, fill_vaddr_d;
    logic [ADDR_W-1:0]   fill_paddr_q, fill_paddr_d;

    // High when D is the winner of the current IDLE-cycle arbitration.
    logic                grant_d;

`ifdef TLB_MISS_SCHED_RR_EN
    // Last granted requester: 0 = I, 1 = D. Reset value 0 lets D win the
    // first tie, after which ties alternate.
    logic                rr_q, rr_d;

    always_comb begin
        grant_d = d_req && (!i_req || !rr_q);
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_comb begin
        // NOTE: every combinational output gets a default before the case
        // statement so no path leaves a signal unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_vaddr_d  = lat_vaddr_q;
        lat_dest_d   = lat_dest_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        fill_valid_d = 1'b0;
        fill_dest_d  = fill_dest_q;
        fill_vaddr_d = fill_vaddr_q;
        fill_paddr_d = fill_paddr_q;
`ifdef TLB_MISS_SCHED_RR_EN
        rr_d         = rr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    lat_vaddr_d = grant_d ? d_vaddr : i_vaddr;
                    lat_dest_d  = grant_d;
                    cnt_d       = CNT_LOAD;
                    i_ack_d     = !grant_d;
                    d_ack_d     = grant_d;
                    state_d     = WALK;
`ifdef TLB_MISS_SCHED_RR_EN
                    rr_d        = grant_d;
`endif
                end
            end

            WALK: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // os_offset is only looked at on this edge; the sum wraps
                    // modulo 2^ADDR_W with the carry dropped.
                    fill_valid_d = 1'b1;
                    fill_dest_d  = lat_dest_q;
                    fill_vaddr_d = lat_vaddr_q;
                    fill_paddr_d = lat_vaddr_q + os_offset;
                    state_d      = FILL;
                end
            end

            FILL: begin
                // Requests are deliberately not sampled here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from the values present before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            lat_vaddr_q  <= '0;
            lat_dest_q   <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_dest_q  <= 1'b0;
            fill_vaddr_q <= '0;
            fill_paddr_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_vaddr_q  <= lat_vaddr_d;
            lat_dest_q   <= lat_dest_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            fill_valid_q <= fill_valid_d;
            fill_dest_q  <= fill_dest_d;
            fill_vaddr_q <= fill_vaddr_d;
            fill_paddr_q <= fill_paddr_d;
        end
    end

`ifdef TLB_MISS_SCHED_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign i_ack      = i_ack_q;
    assign d_ack      = d_ack_q;
    assign fill_valid = fill_valid_q;
    assign fill_dest  = fill_dest_q;
    assign fill_vaddr = fill_vaddr_q;
    assign fill_paddr = fill_paddr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tlb_miss_sched.sv
// -----------------------------------------------------------------------------
// tb_tlb_miss_sched
//
// Directed and randomised stimulus for tlb_miss_sched. Expected values come
// from a behavioural model: the winner is chosen from the set of pending
// requesters (fixed D priority, or alternation when TLB_MISS_SCHED_RR_EN is
// defined), timing follows the cycle numbers of a miss (ack at 1, fill at
// WALK_LAT+1), and the physical address is plain 32-bit addition.
// -----------------------------------------------------------------------------
module tb_tlb_miss_sched;

    localparam int ADDR_W   = 32;
    localparam int WALK_LAT = 4;

    logic              clk;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_vaddr;
    logic              i_ack;
    logic              d_req;
    logic [ADDR_W-1:0] d_vaddr;
    logic              d_ack;
    logic [ADDR_W-1:0] os_offset;
    logic              fill_valid;
    logic              fill_dest;
    logic [ADDR_W-1:0] fill_vaddr;
    logic [ADDR_W-1:0] fill_paddr;
    logic              busy;

    tlb_miss_sched #(
        .ADDR_W   (ADDR_W),
        .WALK_LAT (WALK_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_vaddr    (i_vaddr),
        .i_ack      (i_ack),
        .d_req      (d_req),
        .d_vaddr    (d_vaddr),
        .d_ack      (d_ack),
        .os_offset  (os_offset),
        .fill_valid (fill_valid),
        .fill_dest  (fill_dest),
        .fill_vaddr (fill_vaddr),
        .fill_paddr (fill_paddr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: who was granted last, and what the refill bus last carried.
    bit                last_grant = 1'b0;
    logic              lf_dest    = 1'b0;
    logic [ADDR_W-1:0] lf_va      = '0;
    logic [ADDR_W-1:0] lf_pa      = '0;

    task automatic check(input string tag, input logic [ADDR_W-1:0] obs,
                         input logic [ADDR_W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock, then move 1 time unit past the edge to drive and sample.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick(input bit ir, input bit dr);
        if (ir && dr) begin
`ifdef TLB_MISS_SCHED_RR_EN
            return !last_grant;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},       busy,       '0);
        check({tag, ".i_ack"},      i_ack,      '0);
        check({tag, ".d_ack"},      d_ack,      '0);
        check({tag, ".fill_valid"}, fill_valid, '0);
        check({tag, ".fill_dest"},  fill_dest,  '0);
        check({tag, ".fill_vaddr"}, fill_vaddr, '0);
        check({tag, ".fill_paddr"}, fill_paddr, '0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        #1;
        step();
        reset      = 1'b0;
        last_grant = 1'b0;
        lf_dest    = 1'b0;
        lf_va      = '0;
        lf_pa      = '0;
    endtask

    // Called in the IDLE cycle (cycle 0) with requests already driven. Runs
    // cycles 1..WALK_LAT+1 and ends in the fill cycle.
    task automatic observe_round(input string tag, input bit exp_d,
                                 input logic [ADDR_W-1:0] exp_va,
                                 input logic [ADDR_W-1:0] off,
                                 input bit scramble, input bit drop_winner);
        logic [ADDR_W-1:0] exp_pa;
        exp_pa = exp_va + off;
        for (int k = 1; k <= WALK_LAT + 1; k++) begin
            step();
            if (k <= WALK_LAT) begin
                os_offset = (scramble && k < WALK_LAT) ? ADDR_W'($urandom) : off;
            end
            check({tag, ".busy"},       busy,       1'b1);
            check({tag, ".i_ack"},      i_ack,      (k == 1) && !exp_d);
            check({tag, ".d_ack"},      d_ack,      (k == 1) && exp_d);
            check({tag, ".fill_valid"}, fill_valid, k == WALK_LAT + 1);
            if (k == 1 && drop_winner) begin
                if (exp_d) d_req = 1'b0;
                else       i_req = 1'b0;
            end
        end
        check({tag, ".fill_dest"},  fill_dest,  exp_d);
        check({tag, ".fill_vaddr"}, fill_vaddr, exp_va);
        check({tag, ".fill_paddr"}, fill_paddr, exp_pa);
        last_grant = exp_d;
        lf_dest    = exp_d;
        lf_va      = exp_va;
        lf_pa      = exp_pa;
    endtask

    // Steps into the IDLE cycle after a fill; refill fields must hold.
    task automatic idle_gap(input string tag);
        step();
        check({tag, ".busy"},       busy,       1'b0);
        check({tag, ".i_ack"},      i_ack,      1'b0);
        check({tag, ".d_ack"},      d_ack,      1'b0);
        check({tag, ".fill_valid"}, fill_valid, 1'b0);
        check({tag, ".hold_dest"},  fill_dest,  lf_dest);
        check({tag, ".hold_vaddr"}, fill_vaddr, lf_va);
        check({tag, ".hold_paddr"}, fill_paddr, lf_pa);
    endtask

    initial begin
        bit                i_pend;
        bit                d_pend;
        bit                w;
        logic [ADDR_W-1:0] i_va;
        logic [ADDR_W-1:0] d_va;
        logic [ADDR_W-1:0] off;

        i_req     = 1'b0;
        d_req     = 1'b0;
        i_vaddr   = '0;
        d_vaddr   = '0;
        os_offset = '0;
        reset     = 1'b1;

        // Reset, then 10 idle cycles with every output at zero.
        step();
        check_all_zero("in_reset");
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check_all_zero("idle_after_reset");
        end

        // Single I miss.
        i_vaddr = 32'h0000_1000;
        i_req   = 1'b1;
        observe_round("single_i", 1'b0, 32'h0000_1000, 32'h8000_0000, 1'b0, 1'b1);
        check("single_i.paddr_const", fill_paddr, 32'h8000_1000);
        idle_gap("single_i.gap");

        // D miss whose sum wraps past 2^32.
        d_vaddr = 32'hFFFF_FFF0;
        d_req   = 1'b1;
        observe_round("wrap_d", 1'b1, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b1);
        check("wrap_d.paddr_const", fill_paddr, 32'h0000_0010);
        idle_gap("wrap_d.gap");

        // Tie: winner drops after ack, loser stays pending and is served
        // next with its ack at cycle WALK_LAT+3.
        reset_dut();
        i_vaddr = 32'h0000_A000;
        d_vaddr = 32'h0000_B000;
        i_req   = 1'b1;
        d_req   = 1'b1;
        w = pick(1'b1, 1'b1);
        observe_round("tie1", w, w ? d_vaddr : i_vaddr, 32'h0001_0000, 1'b0, 1'b1);
        idle_gap("tie1.gap");
        w = pick(i_req, d_req);
        observe_round("tie1_loser", w, w ? d_vaddr : i_vaddr, 32'h0001_0000, 1'b0, 1'b1);
        idle_gap("tie1_loser.gap");

        // Both requests held through three back-to-back tie rounds.
        reset_dut();
        i_req = 1'b1;
        d_req = 1'b1;
        for (int r = 0; r < 3; r++) begin
            w = pick(1'b1, 1'b1);
            observe_round("tie3", w, w ? d_vaddr : i_vaddr, 32'h0000_0100, 1'b0, 1'b0);
            if (r == 2) begin
                step();
                i_req = 1'b0;
                d_req = 1'b0;
                check("tie3.busy_end", busy, 1'b0);
            end else begin
                idle_gap("tie3.gap");
            end
        end
        idle_gap("tie3.quiet");

        // Reset during WALK cycle 2 abandons the miss.
        i_vaddr = 32'h0000_3000;
        i_req   = 1'b1;
        step();
        check("rst_walk.i_ack", i_ack, 1'b1);
        i_req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check_all_zero("rst_walk.async");
        step();
        step();
        reset      = 1'b0;
        last_grant = 1'b0;
        lf_dest    = 1'b0;
        lf_va      = '0;
        lf_pa      = '0;
        for (int c = 0; c < WALK_LAT + 2; c++) begin
            step();
            check("rst_walk.no_fill", fill_valid, 1'b0);
            check("rst_walk.busy", busy, 1'b0);
        end
        i_req = 1'b1;
        observe_round("rst_walk.reissue", 1'b0, 32'h0000_3000, 32'h0000_0040, 1'b0, 1'b1);
        idle_gap("rst_walk.gap");

        // os_offset changing during WALK: only the WALK->FILL value counts.
        d_vaddr = 32'h1234_0000;
        d_req   = 1'b1;
        observe_round("offset_change", 1'b1, 32'h1234_0000, 32'h0000_5678, 1'b1, 1'b1);
        idle_gap("offset_change.gap");

        // Randomised traffic against the model.
        i_pend = 1'b0;
        d_pend = 1'b0;
        i_va   = '0;
        d_va   = '0;
        for (int n = 0; n < 30; n++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1'b1;
                i_va   = ADDR_W'($urandom);
            end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                d_pend = 1'b1;
                d_va   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : ADDR_W'($urandom);
            end
            if (!i_pend && !d_pend) begin
                i_pend = 1'b1;
                i_va   = ADDR_W'($urandom);
            end
            i_req   = i_pend;
            i_vaddr = i_va;
            d_req   = d_pend;
            d_vaddr = d_va;
            w   = pick(i_pend, d_pend);
            off = ADDR_W'($urandom);
            observe_round("rand", w, w ? d_va : i_va, off,
                          $urandom_range(0, 1) == 1, 1'b1);
            if (w) d_pend = 1'b0;
            else   i_pend = 1'b0;
            idle_gap("rand.gap");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
